// File: rtl/imba_menu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : imba_menu_ctrl
// Description : Navigation controller for the clap-activated on-screen menu.
//               Debounces the UP/DOWN/SELECT buttons, walks the page/cursor
//               state machine, and holds the display/analysis settings that
//               are chosen from the menu.
// Ports       : CLK_VGA         - system clock, rising edge
//               RESET_N         - asynchronous active-low reset
//               CLAP_PULSE      - one-cycle pulse per detected clap
//               BTN_UP/DOWN/SEL - raw push-buttons, active high
//               Menu_Clap       - menu visible
//               menu_state      - page: 00 MAIN, 01 WAVE, 10 DISPLAY, 11 ANALYSIS
//               menu_cursor     - highlighted item index on the current page
//               wave_sel        - 00 default, 01 pulsar, 10 blocks, 11 none
//               axis_on/grid_on/ticks_on - display enables
//               fft_on/amp_on   - analysis enables
//               setting_changed - one-cycle pulse on every settings write
// Revision    : 1.0 - initial release
// ============================================================================
module imba_menu_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic       CLK_VGA,
    input  logic       RESET_N,
    input  logic       CLAP_PULSE,
    input  logic       BTN_UP,
    input  logic       BTN_DOWN,
    input  logic       BTN_SEL,
    output logic       Menu_Clap,
    output logic [1:0] menu_state,
    output logic [2:0] menu_cursor,
    output logic [1:0] wave_sel,
    output logic       axis_on,
    output logic       grid_on,
    output logic       ticks_on,
    output logic       fft_on,
    output logic       amp_on,
    output logic       setting_changed
);

    typedef enum logic [1:0] {
        PG_MAIN     = 2'b00,
        PG_WAVE     = 2'b01,
        PG_DISPLAY  = 2'b10,
        PG_ANALYSIS = 2'b11
    } page_t;

    localparam logic [CNT_W-1:0] c_dbn_max = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_dbn_pre = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Button debounce: index 0 = UP, 1 = DOWN, 2 = SEL
    // ------------------------------------------------------------------------
    logic [2:0] w_btn_raw;
    logic [2:0] w_press;

    assign w_btn_raw = {BTN_SEL, BTN_DOWN, BTN_UP};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic             r_sync1;
            logic             r_sync2;
            logic [CNT_W-1:0] r_cnt;
            logic             r_press;

            // The counter stops at the threshold so a long hold yields a
            // single pulse; the pulse is flagged on the step that reaches it.
            always_ff @(posedge CLK_VGA or negedge RESET_N) begin
                if (!RESET_N) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_cnt   <= '0;
                    r_press <= 1'b0;
                end else begin
                    r_sync1 <= w_btn_raw[gi];
                    r_sync2 <= r_sync1;
                    r_press <= r_sync2 && (r_cnt == c_dbn_pre);
                    if (!r_sync2) begin
                        r_cnt <= '0;
                    end else if (r_cnt != c_dbn_max) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_press[gi] = r_press;
        end
    endgenerate

    logic w_up;
    logic w_down;
    logic w_sel;

    assign w_up   = w_press[0];
    assign w_down = w_press[1];
    assign w_sel  = w_press[2];

    // ------------------------------------------------------------------------
    // Menu state registers
    // ------------------------------------------------------------------------
    logic       r_visible;
    page_t      r_page;
    logic [2:0] r_cursor;
    logic [1:0] r_wave_sel;
    logic       r_axis_on;
    logic       r_grid_on;
    logic       r_ticks_on;
    logic       r_fft_on;
    logic       r_amp_on;
    logic       r_changed;

    logic       w_visible_nxt;
    page_t      w_page_nxt;
    logic [2:0] w_cursor_nxt;
    logic [1:0] w_wave_sel_nxt;
    logic       w_axis_nxt;
    logic       w_grid_nxt;
    logic       w_ticks_nxt;
    logic       w_fft_nxt;
    logic       w_amp_nxt;
    logic       w_changed_nxt;
    logic [2:0] w_last;

    function automatic logic [2:0] f_item_count(input page_t p);
        logic [2:0] n;
        case (p)
            PG_MAIN:     n = 3'd3;
            PG_WAVE:     n = 3'd5;
            PG_DISPLAY:  n = 3'd4;
            PG_ANALYSIS: n = 3'd3;
            default:     n = 3'd3;
        endcase
        return n;
    endfunction

    always_ff @(posedge CLK_VGA or negedge RESET_N) begin
        if (!RESET_N) begin
            r_visible  <= 1'b0;
            r_page     <= PG_MAIN;
            r_cursor   <= 3'd0;
            r_wave_sel <= 2'b00;
            r_axis_on  <= 1'b1;
            r_grid_on  <= 1'b0;
            r_ticks_on <= 1'b0;
            r_fft_on   <= 1'b0;
            r_amp_on   <= 1'b0;
            r_changed  <= 1'b0;
        end else begin
            r_visible  <= w_visible_nxt;
            r_page     <= w_page_nxt;
            r_cursor   <= w_cursor_nxt;
            r_wave_sel <= w_wave_sel_nxt;
            r_axis_on  <= w_axis_nxt;
            r_grid_on  <= w_grid_nxt;
            r_ticks_on <= w_ticks_nxt;
            r_fft_on   <= w_fft_nxt;
            r_amp_on   <= w_amp_nxt;
            r_changed  <= w_changed_nxt;
        end
    end

    // Event priority: CLAP, then SEL, then UP/DOWN. Only one event is acted
    // on per cycle; anything lower in the same cycle is dropped.
    always_comb begin
        w_visible_nxt  = r_visible;
        w_page_nxt     = r_page;
        w_cursor_nxt   = r_cursor;
        w_wave_sel_nxt = r_wave_sel;
        w_axis_nxt     = r_axis_on;
        w_grid_nxt     = r_grid_on;
        w_ticks_nxt    = r_ticks_on;
        w_fft_nxt      = r_fft_on;
        w_amp_nxt      = r_amp_on;
        w_changed_nxt  = 1'b0;
        w_last         = f_item_count(r_page) - 3'd1;

        if (CLAP_PULSE) begin
            if (!r_visible) begin
                w_visible_nxt = 1'b1;
                w_page_nxt    = PG_MAIN;
                w_cursor_nxt  = 3'd0;
            end else begin
                w_visible_nxt = 1'b0;
            end
        end else if (r_visible) begin
            if (w_sel) begin
                case (r_page)
                    PG_MAIN: begin
                        // MAIN items 0..2 map directly onto pages 1..3
                        w_page_nxt   = page_t'(r_cursor[1:0] + 2'd1);
                        w_cursor_nxt = 3'd0;
                    end
                    PG_WAVE: begin
                        if (r_cursor == w_last) begin
                            w_page_nxt   = PG_MAIN;
                            w_cursor_nxt = 3'd0;
                        end else begin
                            w_wave_sel_nxt = r_cursor[1:0];
                            w_changed_nxt  = 1'b1;
                        end
                    end
                    PG_DISPLAY: begin
                        case (r_cursor)
                            3'd0: begin
                                w_axis_nxt    = ~r_axis_on;
                                w_changed_nxt = 1'b1;
                            end
                            3'd1: begin
                                w_grid_nxt    = ~r_grid_on;
                                w_changed_nxt = 1'b1;
                            end
                            3'd2: begin
                                w_ticks_nxt   = ~r_ticks_on;
                                w_changed_nxt = 1'b1;
                            end
                            default: begin
                                w_page_nxt   = PG_MAIN;
                                w_cursor_nxt = 3'd1;
                            end
                        endcase
                    end
                    default: begin
                        case (r_cursor)
                            3'd0: begin
                                w_fft_nxt     = ~r_fft_on;
                                w_changed_nxt = 1'b1;
                            end
                            3'd1: begin
                                w_amp_nxt     = ~r_amp_on;
                                w_changed_nxt = 1'b1;
                            end
                            default: begin
                                w_page_nxt   = PG_MAIN;
                                w_cursor_nxt = 3'd2;
                            end
                        endcase
                    end
                endcase
            end else if (w_up && !w_down) begin
                w_cursor_nxt = (r_cursor == 3'd0) ? w_last : r_cursor - 3'd1;
            end else if (w_down && !w_up) begin
                w_cursor_nxt = (r_cursor >= w_last) ? 3'd0 : r_cursor + 3'd1;
            end
        end
    end

    assign Menu_Clap       = r_visible;
    assign menu_state      = r_page;
    assign menu_cursor     = r_cursor;
    assign wave_sel        = r_wave_sel;
    assign axis_on         = r_axis_on;
    assign grid_on         = r_grid_on;
    assign ticks_on        = r_ticks_on;
    assign fft_on          = r_fft_on;
    assign amp_on          = r_amp_on;
    assign setting_changed = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_imba_menu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_imba_menu_ctrl
// Description : Directed self-checking bench for imba_menu_ctrl with a
//               debounce threshold of 4 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imba_menu_ctrl;

    logic       clk;
    logic       rst_n;
    logic       clap;
    logic       b_up;
    logic       b_down;
    logic       b_sel;
    logic       menu_clap;
    logic [1:0] menu_state;
    logic [2:0] menu_cursor;
    logic [1:0] wave_sel;
    logic       axis_on;
    logic       grid_on;
    logic       ticks_on;
    logic       fft_on;
    logic       amp_on;
    logic       setting_changed;

    int total;
    int bad;
    int chg_cnt;

    imba_menu_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (20)
    ) dut (
        .CLK_VGA        (clk),
        .RESET_N        (rst_n),
        .CLAP_PULSE     (clap),
        .BTN_UP         (b_up),
        .BTN_DOWN       (b_down),
        .BTN_SEL        (b_sel),
        .Menu_Clap      (menu_clap),
        .menu_state     (menu_state),
        .menu_cursor    (menu_cursor),
        .wave_sel       (wave_sel),
        .axis_on        (axis_on),
        .grid_on        (grid_on),
        .ticks_on       (ticks_on),
        .fft_on         (fft_on),
        .amp_on         (amp_on),
        .setting_changed(setting_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts the cycles in which setting_changed is high.
    always @(negedge clk) begin
        if (setting_changed === 1'b1) chg_cnt = chg_cnt + 1;
    end

    // Stimulus only: hold the masked buttons (bit0 UP, bit1 DOWN, bit2 SEL)
    // for 'hold' cycles, release, then let the debouncers settle.
    task automatic press(input logic [2:0] m, input int hold);
        b_up   = m[0];
        b_down = m[1];
        b_sel  = m[2];
        repeat (hold) @(posedge clk);
        #1;
        b_up   = 1'b0;
        b_down = 1'b0;
        b_sel  = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic clap_once();
        clap = 1'b1;
        @(posedge clk);
        #1;
        clap = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total += 10;
        if (menu_clap !== 1'b0)     begin bad++; $display("FAIL reset_menu_clap: got %b want 0", menu_clap); end
        if (menu_state !== 2'b00)   begin bad++; $display("FAIL reset_state: got %b want 00", menu_state); end
        if (menu_cursor !== 3'd0)   begin bad++; $display("FAIL reset_cursor: got %0d want 0", menu_cursor); end
        if (wave_sel !== 2'b00)     begin bad++; $display("FAIL reset_wave: got %b want 00", wave_sel); end
        if (axis_on !== 1'b1)       begin bad++; $display("FAIL reset_axis: got %b want 1", axis_on); end
        if (grid_on !== 1'b0)       begin bad++; $display("FAIL reset_grid: got %b want 0", grid_on); end
        if (ticks_on !== 1'b0)      begin bad++; $display("FAIL reset_ticks: got %b want 0", ticks_on); end
        if (fft_on !== 1'b0)        begin bad++; $display("FAIL reset_fft: got %b want 0", fft_on); end
        if (amp_on !== 1'b0)        begin bad++; $display("FAIL reset_amp: got %b want 0", amp_on); end
        if (setting_changed !== 1'b0) begin bad++; $display("FAIL reset_chg: got %b want 0", setting_changed); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_clap_open();
        clap_once();
        total += 5;
        if (menu_clap !== 1'b1)   begin bad++; $display("FAIL open_menu_clap: got %b want 1", menu_clap); end
        if (menu_state !== 2'b00) begin bad++; $display("FAIL open_state: got %b want 00", menu_state); end
        if (menu_cursor !== 3'd0) begin bad++; $display("FAIL open_cursor: got %0d want 0", menu_cursor); end
        if (axis_on !== 1'b1)     begin bad++; $display("FAIL open_axis: got %b want 1", axis_on); end
        if ({grid_on, ticks_on, fft_on, amp_on} !== 4'b0000) begin
            bad++; $display("FAIL open_enables: got %b want 0000", {grid_on, ticks_on, fft_on, amp_on});
        end
    endtask

    task automatic test_debounce();
        press(3'b010, 3);
        total++;
        if (menu_cursor !== 3'd0) begin bad++; $display("FAIL short_down: got %0d want 0", menu_cursor); end
        press(3'b010, 20);
        total++;
        if (menu_cursor !== 3'd1) begin bad++; $display("FAIL long_down: got %0d want 1", menu_cursor); end
        press(3'b001, 10);
        total++;
        if (menu_cursor !== 3'd0) begin bad++; $display("FAIL up_1_to_0: got %0d want 0", menu_cursor); end
        press(3'b001, 10);
        total++;
        if (menu_cursor !== 3'd2) begin bad++; $display("FAIL up_wrap: got %0d want 2", menu_cursor); end
        press(3'b011, 10);
        total++;
        if (menu_cursor !== 3'd2) begin bad++; $display("FAIL up_down_both: got %0d want 2", menu_cursor); end
        press(3'b010, 10);
        total++;
        if (menu_cursor !== 3'd0) begin bad++; $display("FAIL down_wrap: got %0d want 0", menu_cursor); end
    endtask

    task automatic test_wave_select();
        int c0;
        press(3'b100, 10);
        total += 2;
        if (menu_state !== 2'b01) begin bad++; $display("FAIL enter_wave_state: got %b want 01", menu_state); end
        if (menu_cursor !== 3'd0) begin bad++; $display("FAIL enter_wave_cursor: got %0d want 0", menu_cursor); end
        press(3'b010, 10);
        press(3'b010, 10);
        c0 = chg_cnt;
        press(3'b100, 10);
        total += 3;
        if (wave_sel !== 2'b10)   begin bad++; $display("FAIL wave_sel_blocks: got %b want 10", wave_sel); end
        if (chg_cnt - c0 !== 1)   begin bad++; $display("FAIL wave_chg_pulse: got %0d cycles want 1", chg_cnt - c0); end
        if (menu_state !== 2'b01) begin bad++; $display("FAIL wave_stays: got %b want 01", menu_state); end
    endtask

    task automatic test_wave_back();
        press(3'b010, 10);
        press(3'b010, 10);
        total++;
        if (menu_cursor !== 3'd4) begin bad++; $display("FAIL wave_cursor_back: got %0d want 4", menu_cursor); end
        press(3'b100, 10);
        total += 2;
        if (menu_state !== 2'b00) begin bad++; $display("FAIL wave_back_state: got %b want 00", menu_state); end
        if (menu_cursor !== 3'd0) begin bad++; $display("FAIL wave_back_cursor: got %0d want 0", menu_cursor); end
        press(3'b100, 10);
        for (int i = 0; i < 4; i++) press(3'b010, 10);
        for (int i = 0; i < 5; i++) press(3'b010, 10);
        total++;
        if (menu_cursor !== 3'd4) begin bad++; $display("FAIL wave_down5_wrap: got %0d want 4", menu_cursor); end
        press(3'b100, 10);
        total++;
        if (menu_state !== 2'b00) begin bad++; $display("FAIL wave_back2_state: got %b want 00", menu_state); end
    endtask

    task automatic test_display();
        int c0;
        press(3'b010, 10);
        press(3'b100, 10);
        total++;
        if (menu_state !== 2'b10) begin bad++; $display("FAIL enter_display: got %b want 10", menu_state); end
        press(3'b010, 10);
        c0 = chg_cnt;
        press(3'b100, 10);
        total++;
        if (grid_on !== 1'b1) begin bad++; $display("FAIL grid_toggle_on: got %b want 1", grid_on); end
        press(3'b100, 10);
        total += 3;
        if (grid_on !== 1'b0)   begin bad++; $display("FAIL grid_toggle_off: got %b want 0", grid_on); end
        if (chg_cnt - c0 !== 2) begin bad++; $display("FAIL grid_chg_pulses: got %0d want 2", chg_cnt - c0); end
        if (axis_on !== 1'b1)   begin bad++; $display("FAIL display_axis_kept: got %b want 1", axis_on); end
        press(3'b010, 10);
        press(3'b010, 10);
        press(3'b100, 10);
        total += 2;
        if (menu_state !== 2'b00) begin bad++; $display("FAIL display_back_state: got %b want 00", menu_state); end
        if (menu_cursor !== 3'd1) begin bad++; $display("FAIL display_back_cursor: got %0d want 1", menu_cursor); end
    endtask

    task automatic test_analysis();
        press(3'b010, 10);
        press(3'b100, 10);
        total++;
        if (menu_state !== 2'b11) begin bad++; $display("FAIL enter_analysis: got %b want 11", menu_state); end
        press(3'b100, 10);
        total += 2;
        if (fft_on !== 1'b1) begin bad++; $display("FAIL fft_toggle: got %b want 1", fft_on); end
        if (amp_on !== 1'b0) begin bad++; $display("FAIL amp_kept: got %b want 0", amp_on); end
        press(3'b001, 10);
        total++;
        if (menu_cursor !== 3'd2) begin bad++; $display("FAIL analysis_up_wrap: got %0d want 2", menu_cursor); end
        press(3'b100, 10);
        total += 2;
        if (menu_state !== 2'b00) begin bad++; $display("FAIL analysis_back_state: got %b want 00", menu_state); end
        if (menu_cursor !== 3'd2) begin bad++; $display("FAIL analysis_back_cursor: got %0d want 2", menu_cursor); end
    endtask

    task automatic test_clap_priority();
        int c0;
        c0 = chg_cnt;
        // SEL raised now; its debounced pulse lands on the 7th edge, which
        // is the edge the clap pulse is presented on.
        b_sel = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        clap = 1'b1;
        @(posedge clk);
        #1;
        clap = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        b_sel = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        total += 4;
        if (menu_clap !== 1'b0)   begin bad++; $display("FAIL clap_sel_close: got %b want 0", menu_clap); end
        if (menu_state !== 2'b00) begin bad++; $display("FAIL clap_sel_state: got %b want 00", menu_state); end
        if (menu_cursor !== 3'd2) begin bad++; $display("FAIL clap_sel_cursor: got %0d want 2", menu_cursor); end
        if (chg_cnt - c0 !== 0)   begin bad++; $display("FAIL clap_sel_chg: got %0d want 0", chg_cnt - c0); end
        press(3'b010, 10);
        press(3'b100, 10);
        total += 4;
        if (menu_clap !== 1'b0)   begin bad++; $display("FAIL hidden_clap: got %b want 0", menu_clap); end
        if (menu_state !== 2'b00) begin bad++; $display("FAIL hidden_state: got %b want 00", menu_state); end
        if (menu_cursor !== 3'd2) begin bad++; $display("FAIL hidden_cursor: got %0d want 2", menu_cursor); end
        if (chg_cnt - c0 !== 0)   begin bad++; $display("FAIL hidden_chg: got %0d want 0", chg_cnt - c0); end
    endtask

    task automatic test_reset_mid_press();
        clap_once();
        b_down = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total += 5;
        if (menu_clap !== 1'b0) begin bad++; $display("FAIL midrst_clap: got %b want 0", menu_clap); end
        if (fft_on !== 1'b0)    begin bad++; $display("FAIL midrst_fft: got %b want 0", fft_on); end
        if (wave_sel !== 2'b00) begin bad++; $display("FAIL midrst_wave: got %b want 00", wave_sel); end
        if (axis_on !== 1'b1)   begin bad++; $display("FAIL midrst_axis: got %b want 1", axis_on); end
        if (menu_cursor !== 3'd0) begin bad++; $display("FAIL midrst_cursor: got %0d want 0", menu_cursor); end
        repeat (3) @(posedge clk);
        #1;
        b_down = 1'b0;
        rst_n  = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        clap_once();
        total += 2;
        if (menu_clap !== 1'b1)   begin bad++; $display("FAIL postrst_open: got %b want 1", menu_clap); end
        if (menu_cursor !== 3'd0) begin bad++; $display("FAIL postrst_cursor: got %0d want 0", menu_cursor); end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        chg_cnt = 0;
        rst_n   = 1'b0;
        clap    = 1'b0;
        b_up    = 1'b0;
        b_down  = 1'b0;
        b_sel   = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_clap_open();
        test_debounce();
        test_wave_select();
        test_wave_back();
        test_display();
        test_analysis();
        test_clap_priority();
        test_reset_mid_press();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
